// File: rtl/edlo_pkg.sv
// Shared definitions for the op sequencer: NOP encoding, FSM states and
// default program-word field widths.
package edlo_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam int         DEF_INST_BITS = 4;
  localparam int         DEF_ADDR_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/edlo_prog_buffer.sv
// Program buffer: DEPTH words written in order at index count, read
// combinationally by the replay pointer.
module edlo_prog_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are not reset; only the fill level is.
  always_ff @(posedge clk) begin
    if (we) mem[count[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else if (we)    count <= count + CW'(1);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/edlo_op_sequencer.sv
// Replays a host-loaded program of {inst, addr} words to the ALU/memory
// controller, with settle cycles per op and a whole-program repeat count.
module edlo_op_sequencer
  import edlo_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int INST_BITS   = DEF_INST_BITS,
  parameter int SETTLE      = 1,
  parameter int REPEAT_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  input  logic [INST_BITS+ADDR_BITS-1:0] load_data,
  output logic                         load_ready,
  input  logic                         clear,
  input  logic                         start,
  input  logic [REPEAT_BITS-1:0]       repeat_cnt,
  input  logic                         abort,
  output logic [INST_BITS-1:0]         inst_out,
  output logic [ADDR_BITS-1:0]         addr_out,
  output logic                         issue,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = INST_BITS + ADDR_BITS;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t                 state, state_nxt;
  logic [PW-1:0]          pc, pc_nxt;
  logic [REPEAT_BITS-1:0] passes, passes_nxt;
  logic [SW-1:0]          scnt, scnt_nxt;
  logic [WW-1:0]          rd_word;
  logic                   buf_we, buf_clr, slot_end, last;
  logic [CW-1:0]          cnt_nxt;
  logic [INST_BITS-1:0]   inst_nxt;
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic                   issue_nxt, busy_nxt, done_nxt, ready_nxt;

  edlo_prog_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .wdata (load_data),
    .clear (buf_clr),
    .raddr (pc),
    .rdata (rd_word),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      passes     <= '0;
      scnt       <= '0;
      inst_out   <= INST_BITS'(OP_NOP);
      addr_out   <= '0;
      issue      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      passes     <= passes_nxt;
      scnt       <= scnt_nxt;
      inst_out   <= inst_nxt;
      addr_out   <= addr_nxt;
      issue      <= issue_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      load_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    passes_nxt = passes;
    scnt_nxt   = scnt;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;
    slot_end   = 1'b0;
    cnt_nxt    = count;
    done_nxt   = 1'b0;
    last       = ({1'b0, pc} == count - CW'(1));

    case (state)
      ST_IDLE: begin
        // start outranks clear and load in the same cycle
        if (start) begin
          if (count != '0) begin
            state_nxt  = ST_ISSUE;
            pc_nxt     = '0;
            passes_nxt = repeat_cnt;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (clear) begin
          buf_clr = 1'b1;
          cnt_nxt = '0;
        end else if (load_valid && load_ready) begin
          buf_we  = 1'b1;
          cnt_nxt = count + CW'(1);
        end
      end
      ST_ISSUE: begin
        if (SETTLE == 0) begin
          slot_end = 1'b1;
        end else begin
          state_nxt = ST_SETTLE;
          scnt_nxt  = '0;
        end
      end
      ST_SETTLE: begin
        if (scnt == SW'(SETTLE - 1)) slot_end = 1'b1;
        else                         scnt_nxt = scnt + SW'(1);
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (slot_end) begin
      if (!last) begin
        pc_nxt    = pc + PW'(1);
        state_nxt = ST_ISSUE;
      end else if (passes != '0) begin
        passes_nxt = passes - REPEAT_BITS'(1);
        pc_nxt     = '0;
        state_nxt  = ST_ISSUE;
      end else begin
        state_nxt = ST_FINISH;
      end
    end

    // abort overrides every transition above, including the finish pulse
    if (state != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b0;
    end

    issue_nxt = (state == ST_ISSUE) && !abort;
    inst_nxt  = issue_nxt ? rd_word[WW-1:ADDR_BITS] : INST_BITS'(OP_NOP);
    addr_nxt  = issue_nxt ? rd_word[ADDR_BITS-1:0] : '0;
    busy_nxt  = (state_nxt != ST_IDLE);
    ready_nxt = (state_nxt == ST_IDLE) && (cnt_nxt < CW'(DEPTH));
  end

endmodule

// File: tb/tb_edlo_op_sequencer.sv
// Directed bench for edlo_op_sequencer (DEPTH=8, SETTLE=1): load, replay,
// repeat, full buffer, empty start, abort and reset during replay.
module tb_edlo_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       clear;
  logic       start;
  logic [3:0] repeat_cnt;
  logic       abort;
  logic [3:0] inst_out;
  logic [3:0] addr_out;
  logic       issue;
  logic       busy;
  logic       done;
  logic [3:0] count;

  int tests  = 0;
  int failed = 0;

  logic [7:0] prog [8];

  edlo_op_sequencer #(
    .DEPTH       (8),
    .ADDR_BITS   (4),
    .INST_BITS   (4),
    .SETTLE      (1),
    .REPEAT_BITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .clear      (clear),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .inst_out   (inst_out),
    .addr_out   (addr_out),
    .issue      (issue),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Pulse start, then walk every cycle of the replay of prog[0..n-1]:
  // ops at odd offsets, done at n*2*(rep+1)+1, busy until then.
  task automatic run_and_check(input int rep, input int n);
    int total;
    int nissue;
    bit exp_iss;
    int idx;
    repeat_cnt = 4'(rep);
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("issue_after_start", issue, 0);
    total  = n * 2 * (rep + 1) + 1;
    nissue = 0;
    for (int k = 1; k <= total + 1; k++) begin
      tick();
      exp_iss = (k % 2 == 1) && (k < total);
      chk($sformatf("issue_k%0d", k), issue, exp_iss);
      if (exp_iss) begin
        idx = ((k - 1) / 2) % n;
        chk($sformatf("inst_k%0d", k), inst_out, prog[idx][7:4]);
        chk($sformatf("addr_k%0d", k), addr_out, prog[idx][3:0]);
        nissue++;
      end else begin
        chk($sformatf("nop_inst_k%0d", k), inst_out, 0);
        chk($sformatf("nop_addr_k%0d", k), addr_out, 0);
      end
      chk($sformatf("done_k%0d", k), done, (k == total));
      chk($sformatf("busy_k%0d", k), busy, (k < total));
    end
    chk("issue_total", nissue, n * (rep + 1));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    clear      = 1'b0;
    start      = 1'b0;
    repeat_cnt = '0;
    abort      = 1'b0;

    // reset state
    #2;
    chk("rst_inst", inst_out, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_issue", issue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", load_ready, 1);

    // three-word program, single pass
    prog[0] = 8'h12; prog[1] = 8'h35; prog[2] = 8'h47;
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    chk("count_3", count, 3);
    chk("ready_3", load_ready, 1);
    run_and_check(0, 3);

    // same program, three passes
    run_and_check(2, 3);
    chk("count_kept", count, 3);

    // fill buffer, offer one extra word
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("count_cleared", count, 0);
    prog[3] = 8'h9A; prog[4] = 8'hBC; prog[5] = 8'hDE; prog[6] = 8'hF1; prog[7] = 8'h23;
    for (int i = 0; i < 8; i++) load_word(prog[i]);
    chk("count_full", count, 8);
    chk("ready_full", load_ready, 0);
    load_word(8'h66);
    chk("count_full_after_extra", count, 8);
    chk("ready_full_after_extra", load_ready, 0);
    run_and_check(0, 8);

    // start with empty buffer
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("count_empty", count, 0);
    chk("ready_empty", load_ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_issue", issue, 0);
    tick();
    chk("empty_done_clr", done, 0);
    chk("empty_busy2", busy, 0);
    chk("empty_issue2", issue, 0);

    // abort during settle of second op, then replay from word 0
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    repeat_cnt = 4'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_abort_issue", issue, 1);
    chk("pre_abort_inst", inst_out, 4'h3);
    chk("pre_abort_addr", addr_out, 4'h5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_issue", issue, 0);
    chk("abort_inst", inst_out, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_abort_done_%0d", i), done, 0);
      chk($sformatf("post_abort_issue_%0d", i), issue, 0);
    end
    chk("abort_count", count, 3);
    chk("abort_ready", load_ready, 1);
    run_and_check(0, 3);

    // asynchronous reset while the FSM sits in ISSUE
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inst", inst_out, 0);
    chk("mid_rst_issue", issue, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_ready", load_ready, 1);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
